// File: rtl/regalu_seq_pkg.sv
// Shared types for the register-bank/ALU step controller: FSM states and
// the step codes shown on the display while an instruction is being set up.
package regalu_seq_pkg;

  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_OPER  = 3'd1,
    ST_WB    = 3'd2,
    ST_SHOW  = 3'd3,
    ST_FLAGS = 3'd4,
    ST_DEST  = 3'd5
  } state_t;

  localparam int STEP_ADDR = 1;
  localparam int STEP_OPER = 2;

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the step button. Resets its history to 1 so a
// button held through reset does not produce a step.
module step_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic nxt,
  output logic nxt_rise
);

  logic nxt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      nxt_q <= 1'b1;
    end else begin
      nxt_q <= nxt;
    end
  end

  assign nxt_rise = nxt & ~nxt_q;

endmodule

// File: rtl/regalu_stepper.sv
// Button-stepped controller for the lab register bank + ALU: latches addresses,
// operands and function, writes the result back, then pages it out on the display.
module regalu_stepper
  import regalu_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int DISP_W     = 16,
  parameter int FUNC_W     = 4,
  parameter int FLAG_W     = 3,
  parameter bit PROTECT_R0 = 1'b1,
  parameter int NSLICE     = DATA_W / DISP_W,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DISP_W-1:0]  in,
  input  logic               nxt,
  input  logic               auto_run,
  output logic [REG_AW-1:0]  rs1_addr,
  output logic [REG_AW-1:0]  rs2_addr,
  output logic [REG_AW-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data1,
  input  logic [DATA_W-1:0]  rd_data2,
  output logic               wr_en,
  output logic [DATA_W-1:0]  wr_data,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [FUNC_W-1:0]  alu_func,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [FLAG_W-1:0]  alu_flags,
  output logic [DISP_W-1:0]  out,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  localparam int SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NSLICE - 1);

  if (DATA_W % DISP_W != 0) begin : g_chk_data_w
    $error("regalu_stepper: DATA_W must be a multiple of DISP_W");
  end
  if (3 * REG_AW > DISP_W) begin : g_chk_reg_aw
    $error("regalu_stepper: three register addresses must fit in DISP_W");
  end

  state_t              state_q;
  state_t              state_d;
  logic                nxt_rise;
  logic                adv;
  logic                wr_allow;
  logic [DATA_W-1:0]   res_q;
  logic [FLAG_W-1:0]   flags_q;
  logic [SLICE_W-1:0]  slice_q;
  logic                unused_in;

  step_edge_det u_edge (
    .clk      (clk),
    .reset    (reset),
    .nxt      (nxt),
    .nxt_rise (nxt_rise)
  );

  assign adv       = nxt_rise | auto_run;
  assign busy      = (state_q != ST_ADDR);
  assign dbg_state = state_q;
  assign wr_allow  = !(PROTECT_R0 && (rd_addr == '0));
  assign unused_in = ^in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      case (state_q)
        ST_ADDR:  state_d = ST_OPER;
        ST_OPER:  state_d = ST_WB;
        ST_WB:    state_d = (NSLICE > 1) ? ST_SHOW : ST_FLAGS;
        ST_SHOW:  if (slice_q == LAST_SLICE) state_d = ST_FLAGS;
        ST_FLAGS: state_d = ST_DEST;
        ST_DEST:  state_d = ST_ADDR;
        default:  state_d = ST_ADDR;
      endcase
    end
  end

  // The display only ever reads the latched result/flags, so the ALU may
  // change underneath (e.g. after writeback to an operand) without effect.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      rd_addr   <= '0;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      slice_q   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      out       <= '0;
    end else begin
      wr_en <= 1'b0;
      if (adv) begin
        case (state_q)
          ST_ADDR: begin
            rs1_addr <= in[REG_AW-1:0];
            rs2_addr <= in[2*REG_AW-1:REG_AW];
            rd_addr  <= in[3*REG_AW-1:2*REG_AW];
            out      <= DISP_W'(STEP_ADDR);
          end
          ST_OPER: begin
            alu_func  <= in[FUNC_W-1:0];
            alu_a     <= rd_data1;
            alu_b     <= rd_data2;
            alu_shamt <= rd_data2[SHAMT_W-1:0];
            out       <= DISP_W'(STEP_OPER);
          end
          ST_WB: begin
            res_q   <= alu_result;
            flags_q <= alu_flags;
            wr_data <= alu_result;
            wr_en   <= wr_allow;
            out     <= alu_result[DISP_W-1:0];
            slice_q <= SLICE_W'(1);
          end
          ST_SHOW: begin
            out     <= res_q[DISP_W*int'(slice_q) +: DISP_W];
            slice_q <= slice_q + SLICE_W'(1);
          end
          ST_FLAGS: out <= DISP_W'(flags_q);
          ST_DEST:  out <= DISP_W'(rd_addr);
          default:  out <= out;
        endcase
      end
    end
  end

endmodule
